// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one 16x8 single-port-command RAM between requesters A and B.
// Round-robin between the two requesters, with an owner allowed up to MAX_BURST
// back-to-back grants while the other one waits. Granted commands are registered
// onto the RAM ports; the RAM's registered read data is routed back to the owner
// through a 2-stage read-tag pipeline, so read data reaches the requester three
// cycles after its grant.
// Optional grant statistics counters are enabled by defining RAM_ARB_STATS_EN.
module ram_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  input  logic                  req_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic                  gnt_a,
  output logic                  gnt_b,
  output logic                  rvalid_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic                  rvalid_b,
  output logic [DATA_WIDTH-1:0] rdata_b,
  output logic                  ram_rst,
  output logic                  ram_wr_enb,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_rd_enb,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
`ifdef RAM_ARB_STATS_EN
  ,
  input  logic                  stats_clr,
  output logic [15:0]           gcnt_a,
  output logic [15:0]           gcnt_b
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  // 1 = B was served last, so A wins the next tie out of IDLE.
  logic       last_b, last_b_nxt;

  // Muxed view of the command being accepted this cycle.
  logic                  cmd_vld;
  logic                  cmd_we;
  logic                  cmd_own_b;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  // Read-tag pipeline: stage 1 lines up with the RAM read command,
  // stage 2 with the RAM's registered read data.
  logic tag1_vld, tag1_b;
  logic tag2_vld, tag2_b;

  assign ram_rst = ~rst;

  // Arbitration state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of block ordering.
    if (!rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      last_b <= 1'b1;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      last_b <= last_b_nxt;
    end
  end

  // Next-state and grant decode; grants are a pure function of state, cnt and the requests.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_nxt  = state;
    cnt_nxt    = cnt;
    last_b_nxt = last_b;
    gnt_a      = 1'b0;
    gnt_b      = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_a && (!req_b || last_b)) begin
          gnt_a     = 1'b1;
          state_nxt = OWN_A;
          cnt_nxt   = 4'd1;
        end else if (req_b) begin
          gnt_b     = 1'b1;
          state_nxt = OWN_B;
          cnt_nxt   = 4'd1;
        end
      end
      OWN_A: begin
        if (req_a && ((cnt < MAX_CNT) || !req_b)) begin
          gnt_a   = 1'b1;
          cnt_nxt = (cnt < MAX_CNT) ? cnt + 4'd1 : MAX_CNT;
        end else if (req_b) begin
          gnt_b      = 1'b1;
          state_nxt  = OWN_B;
          cnt_nxt    = 4'd1;
          last_b_nxt = 1'b0;
        end else begin
          state_nxt  = IDLE;
          cnt_nxt    = 4'd0;
          last_b_nxt = 1'b0;
        end
      end
      OWN_B: begin
        if (req_b && ((cnt < MAX_CNT) || !req_a)) begin
          gnt_b   = 1'b1;
          cnt_nxt = (cnt < MAX_CNT) ? cnt + 4'd1 : MAX_CNT;
        end else if (req_a) begin
          gnt_a      = 1'b1;
          state_nxt  = OWN_A;
          cnt_nxt    = 4'd1;
          last_b_nxt = 1'b1;
        end else begin
          state_nxt  = IDLE;
          cnt_nxt    = 4'd0;
          last_b_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
    // Nothing is accepted while reset is asserted.
    if (!rst) begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
    end
  end

  // Select the accepted command's fields from the granted requester.
  always_comb begin
    cmd_vld   = gnt_a | gnt_b;
    cmd_own_b = gnt_b;
    cmd_we    = gnt_b ? we_b    : we_a;
    cmd_addr  = gnt_b ? addr_b  : addr_a;
    cmd_wdata = gnt_b ? wdata_b : wdata_a;
  end

  // Register the accepted command onto the RAM write or read port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ram_wr_enb  <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
      ram_rd_enb  <= 1'b0;
      ram_rd_addr <= '0;
    end else begin
      ram_wr_enb <= cmd_vld & cmd_we;
      ram_rd_enb <= cmd_vld & ~cmd_we;
      if (cmd_vld && cmd_we) begin
        ram_wr_addr <= cmd_addr;
        ram_wr_data <= cmd_wdata;
      end
      if (cmd_vld && !cmd_we) begin
        ram_rd_addr <= cmd_addr;
      end
    end
  end

  // Track read ownership alongside the RAM latency; reset drops in-flight reads.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tag1_vld <= 1'b0;
      tag1_b   <= 1'b0;
      tag2_vld <= 1'b0;
      tag2_b   <= 1'b0;
    end else begin
      tag1_vld <= cmd_vld & ~cmd_we;
      tag1_b   <= cmd_own_b;
      tag2_vld <= tag1_vld;
      tag2_b   <= tag1_b;
    end
  end

  // Route the RAM read data to its owner; data is forced to 0 when not valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rvalid_a <= 1'b0;
      rdata_a  <= '0;
      rvalid_b <= 1'b0;
      rdata_b  <= '0;
    end else begin
      rvalid_a <= tag2_vld & ~tag2_b;
      rdata_a  <= (tag2_vld && !tag2_b) ? ram_rd_data : '0;
      rvalid_b <= tag2_vld & tag2_b;
      rdata_b  <= (tag2_vld && tag2_b) ? ram_rd_data : '0;
    end
  end

`ifdef RAM_ARB_STATS_EN
  // Saturating grant counters; stats_clr wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst || stats_clr) begin
      gcnt_a <= 16'd0;
      gcnt_b <= 16'd0;
    end else begin
      if (gnt_a && (gcnt_a != 16'hFFFF)) gcnt_a <= gcnt_a + 16'd1;
      if (gnt_b && (gcnt_b != 16'hFFFF)) gcnt_b <= gcnt_b + 16'd1;
    end
  end
`endif

endmodule
